// File: rtl/nibble_serial_tx.sv
//------------------------------------------------------------------------------
// nibble_serial_tx : sends a latched result word MSB nibble first, with a
//                    programmable transmit clock. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nibble_serial_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int NIBBLE_WIDTH = 4,
    parameter int DIV_WIDTH    = 8,
    parameter int DEFAULT_DIV  = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [DATA_WIDTH-1:0]   Din,
    input  logic                    DinValid,
    input  logic                    ConfigDiv,
    input  logic [DIV_WIDTH-1:0]    Divider,
    output logic                    Busy,
    output logic                    DOutValid,
    output logic                    ClkTx,
    output logic [NIBBLE_WIDTH-1:0] DataOut
);

    localparam int NUM_NIB = DATA_WIDTH / NIBBLE_WIDTH;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int PH_W    = DIV_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [IDX_W-1:0]        idx_q;
    logic [PH_W-1:0]         phase_q;
    logic                    busy_q;
    logic                    valid_q;
    logic                    clktx_q;
    logic [NIBBLE_WIDTH-1:0] data_q;

    logic [DIV_WIDTH-1:0]  div_eff_d;
    logic [PH_W-1:0]       last_phase_d;
    logic [PH_W-1:0]       phase_d;
    logic [DATA_WIDTH-1:0] shift_d;

    // A zero divider would give a zero-length half period, so it is promoted to 1.
    assign div_eff_d    = (Divider == '0) ? DIV_WIDTH'(1) : Divider;
    assign last_phase_d = {div_q, 1'b0} - PH_W'(1);
    assign phase_d      = phase_q + PH_W'(1);
    assign shift_d      = shift_q << NIBBLE_WIDTH;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            shift_q <= '0;
            idx_q   <= '0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            clktx_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ConfigDiv) begin
                        div_q <= div_eff_d;
                    end
                    if (DinValid) begin
                        state_q <= ST_SEND;
                        shift_q <= Din;
                        idx_q   <= '0;
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        clktx_q <= 1'b0;
                        data_q  <= Din[DATA_WIDTH-1 -: NIBBLE_WIDTH];
                    end
                end
                ST_SEND: begin
                    if (phase_q == last_phase_d) begin
                        phase_q <= '0;
                        clktx_q <= 1'b0;
                        if (idx_q == IDX_W'(NUM_NIB - 1)) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            shift_q <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            shift_q <= shift_d;
                            data_q  <= shift_d[DATA_WIDTH-1 -: NIBBLE_WIDTH];
                        end
                    end else begin
                        // ClkTx rises once the phase reaches the half period D.
                        phase_q <= phase_d;
                        clktx_q <= (phase_d >= {1'b0, div_q});
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign DOutValid = valid_q;
    assign ClkTx     = clktx_q;
    assign DataOut   = data_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_tx.sv
//------------------------------------------------------------------------------
// tb_nibble_serial_tx : vector table, corner sequences and random words checked
//                       against a per-cycle reference trace. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_tx;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int NN = DW / NW;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [DW-1:0] Din = '0;
    logic          DinValid = 1'b0;
    logic          ConfigDiv = 1'b0;
    logic [7:0]    Divider = '0;
    logic          Busy;
    logic          DOutValid;
    logic          ClkTx;
    logic [NW-1:0] DataOut;

    int total = 0;
    int bad   = 0;
    int model_div = 1;

    nibble_serial_tx #(
        .DATA_WIDTH  (DW),
        .NIBBLE_WIDTH(NW),
        .DIV_WIDTH   (8),
        .DEFAULT_DIV (1)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Din      (Din),
        .DinValid (DinValid),
        .ConfigDiv(ConfigDiv),
        .Divider  (Divider),
        .Busy     (Busy),
        .DOutValid(DOutValid),
        .ClkTx    (ClkTx),
        .DataOut  (DataOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          cfg;
        logic [7:0]    div;
        logic [DW-1:0] din;
        int            exp_d;
    } vec_t;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic b, input logic v,
                         input logic c, input logic [NW-1:0] d);
        total++;
        if ({Busy, DOutValid, ClkTx, DataOut} !== {b, v, c, d}) begin
            bad++;
            $display("FAIL %s: got busy=%b valid=%b clktx=%b data=%h, want busy=%b valid=%b clktx=%b data=%h",
                     name, Busy, DOutValid, ClkTx, DataOut, b, v, c, d);
        end
    endtask

    // Strobes are already driven; the next edge accepts the word. Checks every
    // cycle of the transfer against a trace built from the word and D, then the
    // idle cycle that follows. inject_at / abort_at < 0 disable those corner cases.
    task automatic run_word(input string name, input logic [DW-1:0] din, input int d,
                            input bit hold, input int inject_at, input int abort_at);
        int n;
        int slot;
        logic [NW-1:0] nib;
        n = NN * 2 * d;
        step();
        ConfigDiv = 1'b0;
        if (!hold) DinValid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            slot = k / (2 * d);
            nib  = NW'(din >> (DW - NW * (slot + 1)));
            check(name, 1'b1, 1'b1, ((k % (2 * d)) >= d), nib);
            if (k == abort_at) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                check({name, "_abort"}, 1'b0, 1'b0, 1'b0, '0);
                model_div = 1;
                return;
            end
            if (k == inject_at) begin
                DinValid  = 1'b1;
                Din       = 32'hFFFF_FFFF;
                ConfigDiv = 1'b1;
                Divider   = 8'd5;
            end else if (k == inject_at + 1) begin
                DinValid  = 1'b0;
                ConfigDiv = 1'b0;
            end
        end
        step();
        check({name, "_end"}, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic start(input logic cfg, input logic [7:0] div, input logic [DW-1:0] din);
        ConfigDiv = cfg;
        Divider   = div;
        Din       = din;
        DinValid  = 1'b1;
        if (cfg) model_div = (div == 8'd0) ? 1 : int'(div);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{cfg: 1'b0, div: 8'd0, din: 32'h1234_5678, exp_d: 1};
        vecs[1] = '{cfg: 1'b1, div: 8'd3, din: 32'hDEAD_BEEF, exp_d: 3};
        vecs[2] = '{cfg: 1'b1, div: 8'd0, din: 32'h0F1E_2D3C, exp_d: 1};
        vecs[3] = '{cfg: 1'b1, div: 8'd2, din: 32'hA5C3_0F96, exp_d: 2};
        vecs[4] = '{cfg: 1'b1, div: 8'd1, din: 32'h8000_0001, exp_d: 1};

        // Outputs must be quiet during and right after reset.
        step();
        check("reset", 1'b0, 1'b0, 1'b0, '0);
        step();
        Reset = 1'b0;
        step();
        check("post_reset", 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 5; i++) begin
            start(vecs[i].cfg, vecs[i].div, vecs[i].din);
            run_word($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_d, 1'b0, -1, -1);
        end

        // Strobes during nibble 2 are ignored; nothing follows the word.
        start(1'b1, 8'd1, 32'h0000_000A);
        run_word("ignore_busy", 32'h0000_000A, 1, 1'b0, 4, -1);
        step();
        check("ignore_idle1", 1'b0, 1'b0, 1'b0, '0);
        step();
        check("ignore_idle2", 1'b0, 1'b0, 1'b0, '0);

        // Reset in nibble 4 aborts and restores the default divider.
        start(1'b1, 8'd3, 32'h1357_9BDF);
        run_word("abort", 32'h1357_9BDF, 3, 1'b0, -1, 4 * 6 + 1);
        step();
        check("abort_idle", 1'b0, 1'b0, 1'b0, '0);
        start(1'b0, 8'd0, 32'h2468_ACE0);
        run_word("after_abort", 32'h2468_ACE0, 1, 1'b0, -1, -1);

        // Continuous DinValid: one idle cycle between words; a divider loaded
        // on the accepting edge governs that word.
        start(1'b0, 8'd0, 32'hCAFE_F00D);
        run_word("cont0", 32'hCAFE_F00D, 1, 1'b1, -1, -1);
        start(1'b0, 8'd0, 32'h0BAD_CAFE);
        run_word("cont1", 32'h0BAD_CAFE, 1, 1'b1, -1, -1);
        start(1'b1, 8'd2, 32'h7654_3210);
        run_word("cont_cfg", 32'h7654_3210, 2, 1'b0, -1, -1);

        for (int r = 0; r < 20; r++) begin
            logic [DW-1:0] rd;
            logic          rc;
            logic [7:0]    rv;
            rd = $urandom;
            rc = 1'($urandom_range(0, 1));
            rv = 8'($urandom_range(0, 4));
            start(rc, rv, rd);
            run_word($sformatf("rand%0d", r), rd, model_div, 1'b0, -1, -1);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want finish before 2ms");
        $fatal(1);
    end

endmodule

`default_nettype wire
